// File: rtl/mux_pipe_arb_pkg.sv
// mux_pipe_arb_pkg: shared mode constants and buffer state encodings for mux_pipe_arb.
package mux_pipe_arb_pkg;
  localparam int MODE_SELECT = 0;
  localparam int MODE_RR = 1;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
endpackage

// File: rtl/mux_pipe_arb_skid.sv
// skid_buffer2: two-entry skid buffer with registered upstream ready.
// Ports: clk, rst_n (async active-low); in_payload/in_valid/in_ready upstream;
// out_payload/out_valid/out_ready downstream. in_ready is low only in FULL.
module skid_buffer2 #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready
);
  import mux_pipe_arb_pkg::*;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d;
  logic accept;
  assign in_ready = state_q != ST_FULL;
  assign accept = in_valid & in_ready;
  assign out_valid = state_q != ST_EMPTY;
  assign out_payload = main_q;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d = ST_ONE;
        main_d = in_payload;
      end
      ST_ONE: if (accept && out_ready) main_d = in_payload;
        else if (accept) begin
          state_d = ST_FULL;
          skid_d = in_payload;
        end else if (out_ready) state_d = ST_EMPTY;
      ST_FULL: if (out_ready) begin
        state_d = ST_ONE;
        main_d = skid_q;
      end
      default: state_d = ST_EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
endmodule

// File: rtl/mux_pipe_arb.sv
// mux_pipe_arb: N-channel registered selector with valid/ready, explicit select or round-robin.
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_ready per channel;
// sel (MODE 0 only); out_data/out_chan/out_valid/out_ready downstream.
module mux_pipe_arb import mux_pipe_arb_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int CHANNELS = 2,
  parameter int MODE = MODE_SELECT,
  localparam int SELW = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [SELW-1:0] ptr_q, ptr_d, c, c_rr;
  logic found, c_ok, c_valid, buf_ready, accept;
  logic [WIDTH-1:0] c_data;
  // Scan ptr+1, ptr+2, ... so the last-served channel gets lowest priority.
  always_comb begin
    c_rr = '0;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++)
      for (int i = 0; i < CHANNELS; i++)
        if (!found && in_valid[i] && i == (int'(ptr_q) + k) % CHANNELS) begin
          found = 1'b1;
          c_rr = SELW'(i);
        end
  end
  assign c = MODE == MODE_RR ? c_rr : sel;
  assign c_ok = MODE == MODE_RR ? found : int'(sel) < CHANNELS;
  always_comb begin
    c_data = '0;
    c_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (c == SELW'(i)) begin
        c_data = in_data[i*WIDTH +: WIDTH];
        c_valid = in_valid[i];
      end
  end
  // buf_ready is registered inside the buffer, so in_ready never sees out_ready.
  assign in_ready = (c_ok && buf_ready) ? CHANNELS'(1) << c : '0;
  assign accept = c_ok & c_valid & buf_ready;
  assign ptr_d = (MODE == MODE_RR && accept) ? c : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= SELW'(CHANNELS - 1);
    else ptr_q <= ptr_d;
  skid_buffer2 #(.PW(SELW + WIDTH)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .in_payload({c, c_data}),
    .in_valid(c_ok & c_valid),
    .in_ready(buf_ready),
    .out_payload({out_chan, out_data}),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
endmodule

// File: tb/tb_mux_pipe_arb.sv
// tb_mux_pipe_arb: directed and randomised checks of mux_pipe_arb in three configurations.
module tb_mux_pipe_arb;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [9:0] d0; logic [1:0] v0, r0; logic s0; logic [4:0] od0; logic oc0, ov0, or0;
  logic [19:0] d1; logic [3:0] v1, r1; logic [1:0] s1; logic [4:0] od1; logic [1:0] oc1; logic ov1, or1;
  logic [14:0] d2; logic [2:0] v2, r2; logic [1:0] s2; logic [4:0] od2; logic [1:0] oc2; logic ov2, or2;
  int tests = 0, fails = 0;
  mux_pipe_arb #(.WIDTH(5), .CHANNELS(2), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .in_data(d0),
    .in_valid(v0), .in_ready(r0), .sel(s0), .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(or0));
  mux_pipe_arb #(.WIDTH(5), .CHANNELS(4), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .in_data(d1),
    .in_valid(v1), .in_ready(r1), .sel(s1), .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(or1));
  mux_pipe_arb #(.WIDTH(5), .CHANNELS(3), .MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .in_data(d2),
    .in_valid(v2), .in_ready(r2), .sel(s2), .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(or2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    logic [1:0] seq [9];
    logic [6:0] q [$];
    int mptr, c;
    logic found, rr, acc;
    logic [3:0] rv, ir_a, exp_r;
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
    d0 = '0; v0 = '0; s0 = 1'b1; or0 = 1'b1;
    d1 = '0; v1 = '0; s1 = '0; or1 = 1'b1;
    d2 = '0; v2 = '0; s2 = '0; or2 = 1'b1;
    #2;
    chk("rst_ov0", 32'(ov0), 0); chk("rst_od0", 32'(od0), 0); chk("rst_oc0", 32'(oc0), 0);
    chk("rst_r0", 32'(r0), 32'h2); chk("rst_r1", 32'(r1), 0); chk("rst_r2", 32'(r2), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = 2'b10; d0 = {5'h1A, 5'h00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("sel_ov", 32'(ov0), 1); chk("sel_od", 32'(od0), 32'h1A);
      chk("sel_oc", 32'(oc0), 1); chk("sel_r", 32'(r0), 32'h2);
    end
    v0 = '0;
    @(negedge clk); #1;
    chk("drain_ov", 32'(ov0), 0);
    or0 = 1'b0; v0 = 2'b10; d0 = {5'h03, 5'h00};
    @(negedge clk); #1;
    chk("bp1_od", 32'(od0), 32'h03); chk("bp1_r", 32'(r0), 32'h2);
    d0 = {5'h04, 5'h00};
    @(negedge clk); #1;
    chk("bp_full_r", 32'(r0), 0); chk("bp_full_od", 32'(od0), 32'h03); chk("bp_full_oc", 32'(oc0), 1);
    s0 = 1'b0; d0 = {5'h05, 5'h07};
    @(negedge clk); #1;
    chk("bp_hold_r", 32'(r0), 0); chk("bp_hold_od", 32'(od0), 32'h03); chk("bp_hold_ov", 32'(ov0), 1);
    or0 = 1'b1; v0 = '0; s0 = 1'b1;
    @(negedge clk); #1;
    chk("bp_rel_od", 32'(od0), 32'h04); chk("bp_rel_ov", 32'(ov0), 1); chk("bp_rel_oc", 32'(oc0), 1);
    @(negedge clk); #1;
    chk("bp_empty_ov", 32'(ov0), 0);
    d1 = {5'd3, 5'd2, 5'd1, 5'd0}; v1 = 4'hF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      chk("rr_ov", 32'(ov1), 1); chk("rr_oc", 32'(oc1), 32'(seq[i])); chk("rr_od", 32'(od1), 32'(seq[i]));
      if (i == 4) v1 = 4'b1010;
    end
    v1 = '0;
    @(negedge clk); #1;
    chk("rr_drain_ov", 32'(ov1), 0);
    s2 = 2'd0; v2 = 3'b111; d2 = {5'h12, 5'h11, 5'h10};
    @(negedge clk); #1;
    chk("oor_pre_ov", 32'(ov2), 1); chk("oor_pre_od", 32'(od2), 32'h10);
    s2 = 2'd3; #1;
    chk("oor_r", 32'(r2), 0);
    @(negedge clk); #1;
    chk("oor_ov", 32'(ov2), 0); chk("oor_r2", 32'(r2), 0);
    or1 = 1'b0; v1 = 4'hF; d1 = {5'h17, 5'h16, 5'h15, 5'h14};
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mid_full_r", 32'(r1), 0); chk("mid_full_od", 32'(od1), 32'h14);
    #1 rst_n = 1'b0; #1;
    chk("mid_rst_ov", 32'(ov1), 0); chk("mid_rst_od", 32'(od1), 0); chk("mid_rst_oc", 32'(oc1), 0);
    chk("mid_rst_r", 32'(r1), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; or1 = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_oc", 32'(oc1), 0); chk("post_rst_od", 32'(od1), 32'h14); chk("post_rst_ov", 32'(ov1), 1);
    v1 = '0;
    @(negedge clk);
    rst_n = 1'b0; #1 rst_n = 1'b1;
    mptr = 3;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rv = 4'($urandom_range(0, 15)); rr = 1'($urandom_range(0, 1)); d1 = 20'($urandom);
      v1 = rv; or1 = ~rr; #1;
      ir_a = r1; or1 = rr; #1;
      found = 1'b0; c = 0;
      for (int k = 1; k <= 4; k++)
        if (!found && rv[(mptr + k) % 4]) begin found = 1'b1; c = (mptr + k) % 4; end
      acc = found && q.size() < 2;
      exp_r = acc ? 4'(1 << c) : 4'h0;
      chk("rnd_ready_indep", 32'(ir_a), 32'(exp_r));
      chk("rnd_ready", 32'(r1), 32'(exp_r));
      chk("rnd_ov", 32'(ov1), 32'(q.size() > 0));
      if (q.size() > 0) chk("rnd_out", 32'({oc1, od1}), 32'(q[0]));
      if (q.size() > 0 && rr) void'(q.pop_front());
      if (acc) begin
        q.push_back({2'(c), d1[c*5 +: 5]});
        mptr = c;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
